// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC range defaults and the prefetch queue entry
// type for the instruction fetch stage.
//   ADDR_W   - instruction memory address / PC width
//   DATA_W   - instruction word width
//   PC_START - reset PC and wrap target
//   PC_WRAP  - last address fetched before the PC returns to PC_START
//   fetch_entry_t - {pc, instr} pair held in the prefetch queue
package fetch_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] PC_START = 5'd12;
  localparam logic [ADDR_W-1:0] PC_WRAP  = 5'd18;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bus bundle of the fetch stage.
//   Memory side : mem_rd, mem_addr (to memory), mem_rdata (from memory)
//   Redirect    : redir_valid, redir_pc (from execute)
//   Decoder side: out_valid, out_instr, out_pc (to decoder), out_ready (from decoder)
// modport master - the fetch unit
// modport slave  - the environment (memory, execute stage, decoder)
interface fetch_if;
  import fetch_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output mem_rd, mem_addr, out_valid, out_instr, out_pc,
    input  mem_rdata, redir_valid, redir_pc, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_valid, out_instr, out_pc,
    output mem_rdata, redir_valid, redir_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t (prefetch queue).
//   clk, rst  - clock, synchronous active-high reset
//   i_clear   - drop all entries (takes priority over push/pop)
//   i_push    - write i_data at the tail
//   i_data    - entry to write
//   i_pop     - remove the head entry
//   o_count   - number of valid entries
//   o_head    - head entry (meaningful only when o_count != 0)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  fetch_entry_t               i_data,
  input  logic                       i_pop,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output fetch_entry_t               o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (i_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_count = r_count;
    o_head  = r_mem[r_rptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues one read per cycle
// to the instruction memory, buffers returned words in a prefetch queue and
// presents {pc, instr} to the decoder over valid/ready. A redirect flushes
// the queue, drops any in-flight return and restarts fetch at redir_pc.
//   clk, rst    - clock, synchronous active-high reset
//   bus         - fetch_if.master: memory read port, redirect input,
//                 decoder output handshake
//   fetch_count - (FETCH_PERF_CNT_EN only) pops, modulo 2^16
//   flush_count - (FETCH_PERF_CNT_EN only) redirect cycles, modulo 2^16
// Optional feature macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [fetch_pkg::ADDR_W-1:0] PC_START = fetch_pkg::PC_START,
  parameter logic [fetch_pkg::ADDR_W-1:0] PC_WRAP  = fetch_pkg::PC_WRAP,
  parameter int unsigned                  DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count,
`endif
  fetch_if.master     bus
);
  import fetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_issued_pc;
  logic              r_inflight;

  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occupancy;
  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic              w_discard;
  logic              w_push;
  fetch_entry_t      w_head;
  fetch_entry_t      w_ret;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.redir_valid),
    .i_push  (w_push),
    .i_data  (w_ret),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_comb begin
    w_valid     = (w_count != '0);
    w_pop       = w_valid && bus.out_ready;
    // Slots committed after this edge; the in-flight read holds a reservation
    // so a return can always be pushed.
    w_occupancy = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
    w_issue     = !rst && !bus.redir_valid && (w_occupancy < (CNT_W+1)'(DEPTH));
    w_pc_next   = (r_pc == PC_WRAP) ? PC_START : r_pc + 1'b1;
    // The return lands in the same cycle as a redirect or reset and is
    // dropped there, so no flag needs to survive into the next cycle.
    w_discard   = r_inflight && (bus.redir_valid || rst);
    w_push      = r_inflight && !w_discard;
    w_ret.pc    = r_issued_pc;
    w_ret.instr = bus.mem_rdata;

    bus.mem_rd    = w_issue;
    bus.mem_addr  = r_pc;
    bus.out_valid = w_valid;
    bus.out_pc    = w_valid ? w_head.pc    : '0;
    bus.out_instr = w_valid ? w_head.instr : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= PC_START;
      r_issued_pc <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_issued_pc <= r_pc;
      end
      if (bus.redir_valid) begin
        r_pc <= bus.redir_pc;
      end else if (w_issue) begin
        r_pc <= w_pc_next;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (w_pop) begin
        fetch_count <= fetch_count + 16'd1;
      end
      if (bus.redir_valid) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a
// synchronous instruction memory model. Inputs change and outputs are
// sampled just after the falling edge.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  fetch_unit #(
    .PC_START (5'd12),
    .PC_WRAP  (5'd18),
    .DEPTH    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .flush_count (flush_count),
`endif
    .bus         (bus)
  );

  logic [31:0] mem [32];

  // Read data valid the cycle after mem_rd; garbage otherwise.
  always @(posedge clk) begin
    bus.mem_rdata <= bus.mem_rd ? mem[bus.mem_addr] : 32'hDEAD_BEEF;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [4:0] rpc);
    @(negedge clk);
    rst             = r;
    bus.out_ready   = rdy;
    bus.redir_valid = rv;
    bus.redir_pc    = rpc;
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic rd, input int addr);
    check({tag, ".mem_rd"}, 32'(bus.mem_rd), 32'(rd));
    if (rd) check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr));
  endtask

  task automatic chk_out(input string tag, input logic v, input int pc);
    logic [4:0] p;
    p = 5'(pc);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".out_pc"}, 32'(bus.out_pc), v ? 32'(p) : 32'd0);
    check({tag, ".out_instr"}, bus.out_instr, v ? mem[p] : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[12] = 32'h0002_0020;
    mem[13] = 32'h0062_0022;
    mem[14] = 32'h0020_0024;
    mem[15] = 32'h0000_0080;
    mem[16] = 32'h8C20_0002;
    mem[17] = 32'h0C00_000D;
    mem[18] = 32'h0800_000F;

    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;

    // Reset state
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("rst.mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst.mem_addr", 32'(bus.mem_addr), 32'd12);
    chk_out("rst", 0, 0);
`ifdef FETCH_PERF_CNT_EN
    check("rst.fetch_count", 32'(fetch_count), 32'd0);
    check("rst.flush_count", 32'(flush_count), 32'd0);
`endif

    // Streaming with out_ready high: addresses 12..18 then wrap to 12
    for (int k = 0; k <= 10; k++) begin
      step(0, 1, 0, 0);
      chk_fetch($sformatf("stream.C%0d", k), 1, 12 + (k % 7));
      if (k >= 2) chk_out($sformatf("stream.C%0d", k), 1, 12 + ((k - 2) % 7));
      else        chk_out($sformatf("stream.C%0d", k), 0, 0);
    end

    // out_ready low from C0: two reads then stall, head held
    step(1, 0, 0, 0);
    for (int c = 0; c <= 4; c++) begin
      step(0, 0, 0, 0);
      chk_fetch($sformatf("stall.C%0d", c), (c < 2), 12 + c);
      chk_out($sformatf("stall.C%0d", c), (c >= 2), 12);
    end
    step(0, 1, 0, 0);
    chk_fetch("stall.C5", 1, 14);
    chk_out("stall.C5", 1, 12);
    step(0, 1, 0, 0);
    chk_fetch("stall.C6", 1, 15);
    chk_out("stall.C6", 1, 13);
    step(0, 1, 0, 0);
    chk_fetch("stall.C7", 1, 16);
    chk_out("stall.C7", 1, 14);
    step(0, 0, 0, 0);
    chk_fetch("stall.C8", 0, 17);
    chk_out("stall.C8", 1, 15);
    step(0, 0, 0, 0);
    chk_fetch("stall.C9", 0, 17);
    chk_out("stall.C9", 1, 15);

    // Reset pulse with the queue full
    step(1, 0, 0, 0);
    check("midrst.mem_rd", 32'(bus.mem_rd), 32'd0);
    step(0, 1, 0, 0);
    chk_fetch("midrst.X1", 1, 12);
    chk_out("midrst.X1", 0, 0);
    step(0, 1, 0, 0);
    chk_fetch("midrst.X2", 1, 13);
    chk_out("midrst.X2", 0, 0);
    step(0, 1, 0, 0);
    chk_fetch("midrst.X3", 1, 14);
    chk_out("midrst.X3", 1, 12);

    // Redirect to 15 with 14 in flight and head 13 popped in the same cycle
    step(0, 1, 1, 15);
    chk_fetch("redir.R", 0, 0);
    chk_out("redir.R", 1, 13);
    step(0, 1, 0, 0);
    chk_fetch("redir.R1", 1, 15);
    chk_out("redir.R1", 0, 0);
    step(0, 1, 0, 0);
    chk_fetch("redir.R2", 1, 16);
    chk_out("redir.R2", 0, 0);
    step(0, 1, 0, 0);
    chk_fetch("redir.R3", 1, 17);
    chk_out("redir.R3", 1, 15);
    step(0, 1, 0, 0);
    chk_out("redir.R4", 1, 16);

    // Back-to-back redirects: 20 then 17, last wins; then wrap 18 -> 12
    step(0, 1, 1, 20);
    chk_fetch("b2b.A", 0, 0);
    step(0, 1, 1, 17);
    chk_fetch("b2b.B", 0, 0);
    chk_out("b2b.B", 0, 0);
    step(0, 1, 0, 0);
    chk_fetch("b2b.1", 1, 17);
    chk_out("b2b.1", 0, 0);
    step(0, 1, 0, 0);
    chk_fetch("b2b.2", 1, 18);
    step(0, 1, 0, 0);
    chk_fetch("b2b.3", 1, 12);
    chk_out("b2b.3", 1, 17);
    step(0, 1, 0, 0);
    chk_out("b2b.4", 1, 18);
    step(0, 1, 0, 0);
    chk_out("b2b.5", 1, 12);

    // Out-of-range target 30: plain 5-bit increment 30, 31, 0
    step(0, 1, 1, 30);
    step(0, 1, 0, 0);
    chk_fetch("oor.1", 1, 30);
    step(0, 1, 0, 0);
    chk_fetch("oor.2", 1, 31);
    step(0, 1, 0, 0);
    chk_fetch("oor.3", 1, 0);
    chk_out("oor.3", 1, 30);
    step(0, 1, 0, 0);
    chk_out("oor.4", 1, 31);
    step(0, 1, 0, 0);
    chk_out("oor.5", 1, 0);

`ifdef FETCH_PERF_CNT_EN
    // 10 pops (C2..C11) then 2 redirects with the decoder stalled
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("perf.rst.fetch_count", 32'(fetch_count), 32'd0);
    check("perf.rst.flush_count", 32'(flush_count), 32'd0);
    for (int c = 0; c < 12; c++) step(0, 1, 0, 0);
    step(0, 0, 1, 5);
    step(0, 0, 1, 6);
    step(0, 0, 0, 0);
    check("perf.fetch_count", 32'(fetch_count), 32'd10);
    check("perf.flush_count", 32'(flush_count), 32'd2);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("perf.clr.fetch_count", 32'(fetch_count), 32'd0);
    check("perf.clr.flush_count", 32'(flush_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction decoder. It owns the program counter, issues one read per cycle to the 32-word instruction memory, and buffers returned words in a small prefetch queue. The queue presents {pc, instruction} to the decoder over a valid/ready handshake. Jump/branch redirects from the execute stage flush the queue and restart fetch at the target.

## Interface
- ADDR_W, 5, instruction memory address / PC width
- DATA_W, 32, instruction word width
- PC_START, 12, reset PC and wrap target
- PC_WRAP, 18, last address fetched before PC returns to PC_START
- DEPTH, 2, prefetch queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- mem_rd  out  1  read strobe to instruction memory
- mem_addr  out  ADDR_W  read address (= PC register)
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd
- redir_valid  in  1  redirect request (j/jal/taken branch)
- redir_pc  in  ADDR_W  redirect target
- out_valid  out  1  queue head valid
- out_ready  in  1  decoder accepts head
- out_instr  out  DATA_W  head instruction; 0 when !out_valid
- out_pc  out  ADDR_W  head PC; 0 when !out_valid

## Operation
- pop = out_valid & out_ready; head removed at the clock edge.
- Issue rule: mem_rd=1 when !rst & !redir_valid & (count + inflight − pop) < DEPTH. inflight is a 1-bit flag set by mem_rd, cleared the following cycle.
- On issue, PC advances: pc_next = (pc==PC_WRAP) ? PC_START : pc+1 (ADDR_W-bit modulo otherwise).
- Return: in the cycle after an issue, mem_rdata and the issued PC are pushed into the queue, unless a discard flag is set.
- Redirect (redir_valid=1): queue cleared, pc←redir_pc, no read issued that cycle. A read already in flight sets discard, and its return is dropped. A pop in the same cycle is a completed transfer; the redirect still clears everything else.
- A redirect target outside [PC_START, PC_WRAP] is accepted as-is. Increment then follows the wrap rule above.
- Back-to-back redirects: the last one wins; each clears the queue.
- Queue never overflows: the issue rule reserves a slot for every in-flight read.

## Timing
- Reset values: pc=PC_START, mem_rd=0, out_valid=0, out_instr=0, out_pc=0, count=0, inflight=0, discard=0. Any return arriving the cycle after rst is dropped.
- Reset mid-operation: same as above in the first clock with rst=1. Queue contents and in-flight reads are lost.
- First cycle after rst deasserts (C0): mem_rd=1, mem_addr=PC_START.
- Fetch-to-decoder latency: 2 cycles. Issue in C0, push at the end of C1, out_valid=1 in C2.
- Throughput with out_ready held high: one instruction per cycle from C2 on.
- Redirect asserted in cycle R:
  - R+1: mem_rd=1 with mem_addr=redir_pc.
  - R+1: out_valid=0.
  - R+3: first target instruction presented.
- out_ready low: the head holds stable. Fetch stalls once count + inflight = DEPTH.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_count (16 bits, increments on every pop) and flush_count (16 bits, increments on every redir_valid cycle).
  - Both wrap modulo 2^16 and reset to 0.
- FETCH_PERF_CNT_EN undefined: neither the ports nor the counters exist.

## Structure
- Shared package fetch_pkg holds:
  - ADDR_W, DATA_W, PC_START, PC_WRAP defaults.
  - typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t with push, pop, clear, count, head.
- PC, issue rule, inflight/discard flags and counters live in fetch_unit.

## Test plan
- Reset release, memory model mem[12..18]=0x00020020, 0x00620022, 0x00200024, 0x00000080, 0x8C200002, 0x0C00000D, 0x0800000F; out_ready=1 → mem_addr 12,13,…,18,12,…; out_pc sequence 12,13,…,18,12 starting C2, with matching out_instr.
- out_ready=0 from C0 → exactly two reads issued (addresses 12, 13). Holds out_pc=12, out_instr=0x00020020 until ready. After ready rises, pops 12 then 13, and reads resume at 14.
- redir_valid=1, redir_pc=15, with a read of 14 in flight → 14 never presented. mem_addr=15 in R+1; out_pc=15 first valid in R+3.
- Redirect and pop in the same cycle with head pc=13 → 13 counted as transferred; queue empty next cycle; fetch resumes at target.
- rst pulsed one cycle while the queue holds 2 entries → out_valid=0 for the next 2 cycles. Fetch restarts at mem_addr=12.
- FETCH_PERF_CNT_EN defined, 10 pops plus 2 redirects → fetch_count=10, flush_count=2; both read 0 after rst.
